// File: rtl/mvm_rr_arbiter.sv
// mvm_rr_arbiter
//
// Shares one layer engine (M x N matrix-vector with bias/ReLU) between two
// requesters.  Ownership is granted for a whole transaction: N input beats
// streamed from the owner into the engine, then M result beats streamed from
// the engine back to the owner.  Ties are broken by a round-robin pointer that
// always favours the requester that was not served last.
//
// Handshake rule used on every channel: a beat transfers on a rising clk edge
// where valid && ready are both high.  A valid that has been raised is held,
// along with its data, until that transfer.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   s0_*/s1_*             requester input-vector beats (valid/ready/data)
//   m0_*/m1_*             result beats back to each requester (valid/ready/data)
//   e_s_valid/e_s_ready   input beats towards the engine, e_data_in
//   e_m_valid/e_m_ready   result beats from the engine, e_data_out
//   grant                 registered one-hot owner (bit0 = req 0), 00 when idle
//   busy                  high whenever the FSM is not idle
//   fsm_state             FSM state (0 idle, 1 load, 2 drain) for observation
module mvm_rr_arbiter #(
  parameter int WIDTH = 20,
  parameter int N     = 8,
  parameter int M     = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s0_valid,
  output logic                    s0_ready,
  input  logic signed [WIDTH-1:0] s0_data,
  input  logic                    s1_valid,
  output logic                    s1_ready,
  input  logic signed [WIDTH-1:0] s1_data,
  output logic                    m0_valid,
  input  logic                    m0_ready,
  output logic signed [WIDTH-1:0] m0_data,
  output logic                    m1_valid,
  input  logic                    m1_ready,
  output logic signed [WIDTH-1:0] m1_data,
  output logic                    e_s_valid,
  input  logic                    e_s_ready,
  output logic signed [WIDTH-1:0] e_data_in,
  input  logic                    e_m_valid,
  output logic                    e_m_ready,
  input  logic signed [WIDTH-1:0] e_data_out,
  output logic [1:0]              grant,
  output logic                    busy,
  output logic [1:0]              fsm_state
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int OW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state;
  logic            rr_ptr;   // requester preferred on the next tie
  logic [IW-1:0]   in_cnt;
  logic [OW-1:0]   out_cnt;
  logic            load;
  logic            drain;
  logic            sel1;     // owner is requester 1
  logic            in_fire;
  logic            out_fire;

  always_comb begin
    load     = (state == ST_LOAD);
    drain    = (state == ST_DRAIN);
    sel1     = grant[1];

    // Input path: only the owner is connected, and only while loading.
    e_s_valid = load && (sel1 ? s1_valid : s0_valid);
    s0_ready  = load && !sel1 && e_s_ready;
    s1_ready  = load &&  sel1 && e_s_ready;
    e_data_in = sel1 ? s1_data : s0_data;

    // Result path: engine results stay parked in the engine outside DRAIN.
    m0_valid  = drain && !sel1 && e_m_valid;
    m1_valid  = drain &&  sel1 && e_m_valid;
    e_m_ready = drain && (sel1 ? m1_ready : m0_ready);
    m0_data   = e_data_out;
    m1_data   = e_data_out;

    in_fire   = e_s_valid && e_s_ready;
    out_fire  = e_m_valid && e_m_ready;

    busy      = (state != ST_IDLE);
    fsm_state = state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      grant   <= 2'b00;
      rr_ptr  <= 1'b0;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // The arbitration cycle consumes no beat; the winner is registered
          // into grant and streaming starts on the following cycle.
          if (s0_valid && s1_valid) begin
            grant <= rr_ptr ? 2'b10 : 2'b01;
            state <= ST_LOAD;
          end else if (s0_valid) begin
            grant <= 2'b01;
            state <= ST_LOAD;
          end else if (s1_valid) begin
            grant <= 2'b10;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (in_fire) begin
            if (in_cnt == IW'(N - 1)) begin
              in_cnt <= '0;
              state  <= ST_DRAIN;
            end else begin
              in_cnt <= in_cnt + IW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (out_fire) begin
            if (out_cnt == OW'(M - 1)) begin
              out_cnt <= '0;
              grant   <= 2'b00;
              // Point at the requester that was not just served:
              // grant 01 -> prefer 1, grant 10 -> prefer 0.
              rr_ptr  <= grant[0];
              state   <= ST_IDLE;
            end else begin
              out_cnt <= out_cnt + OW'(1);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_rr_arbiter.sv
// tb_mvm_rr_arbiter
//
// Bench for mvm_rr_arbiter.  A transaction-level model tracks who owns the
// engine, how many beats of the current vector have moved and the tie-break
// preference; a stub engine absorbs N beats and then offers M random results
// kept in exp_q.  Every cycle the DUT outputs are compared against the model,
// and the observed grant order / idle gaps are compared against fixed
// expectations for the directed scenarios.
module tb_mvm_rr_arbiter;
  localparam int WIDTH = 20;
  localparam int N     = 8;
  localparam int M     = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             sv[2];
  logic [WIDTH-1:0] sd[2];
  logic             mr[2];
  logic             s0_ready, s1_ready, m0_valid, m1_valid;
  logic [WIDTH-1:0] m0_data, m1_data;
  logic             e_s_valid, e_s_ready, e_m_valid, e_m_ready;
  logic [WIDTH-1:0] e_data_in, e_data_out;
  logic [1:0]       grant, fsm_state;
  logic             busy;

  // clock / reset
  always #5 clk = ~clk;

  mvm_rr_arbiter #(.WIDTH(WIDTH), .N(N), .M(M)) dut (
    .clk(clk), .reset(reset),
    .s0_valid(sv[0]), .s0_ready(s0_ready), .s0_data(sd[0]),
    .s1_valid(sv[1]), .s1_ready(s1_ready), .s1_data(sd[1]),
    .m0_valid(m0_valid), .m0_ready(mr[0]), .m0_data(m0_data),
    .m1_valid(m1_valid), .m1_ready(mr[1]), .m1_data(m1_data),
    .e_s_valid(e_s_valid), .e_s_ready(e_s_ready), .e_data_in(e_data_in),
    .e_m_valid(e_m_valid), .e_m_ready(e_m_ready), .e_data_out(e_data_out),
    .grant(grant), .busy(busy), .fsm_state(fsm_state)
  );

  // scoreboard / model state
  logic [WIDTH-1:0] src0_q[$];
  logic [WIDTH-1:0] src1_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [1:0]       grant_log[$];
  int               gap_log[$];
  int               idle_run;
  logic [1:0]       prev_grant;
  int               m_owner;   // -1 when nobody owns the engine
  int               m_ptr;
  int               m_in;
  int               m_out;
  bit               m_drain;
  int               p_sv, p_er, p_ev, p_mr;
  bit               toggle_m0;
  int               checks = 0;
  int               errors = 0;

  function automatic logic [31:0] b(input logic v);
    return {31'b0, v};
  endfunction

  function automatic bit rnd(input int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int src_size(input int x);
    return (x == 1) ? src1_q.size() : src0_q.size();
  endfunction

  task automatic push_txn(input int x, input bit seq);
    logic [WIDTH-1:0] v;
    for (int i = 0; i < N; i++) begin
      v = seq ? WIDTH'(i + 1) : WIDTH'($urandom);
      if (x == 1) src1_q.push_back(v); else src0_q.push_back(v);
    end
  endtask

  task automatic clear_logs();
    grant_log.delete();
    gap_log.delete();
    idle_run = 0;
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_in = 0; m_out = 0; m_drain = 1'b0;
    src0_q.delete(); src1_q.delete(); exp_q.delete();
    sv[0] = 1'b0; sv[1] = 1'b0; sd[0] = '0; sd[1] = '0;
    e_m_valid = 1'b0; e_data_out = '0;
  endtask

  // driver: update requester sources, engine stub and result sinks
  task automatic drive_inputs(input bit f0, input bit f1, input bit out_fire);
    for (int x = 0; x < 2; x++) begin
      if (!sv[x] || (x == 0 ? f0 : f1)) sv[x] = (src_size(x) > 0) && rnd(p_sv);
      if (src_size(x) > 0) sd[x] = (x == 1) ? src1_q[0] : src0_q[0];
      else sd[x] = '0;
    end
    e_s_ready = rnd(p_er);
    if (!e_m_valid || out_fire) e_m_valid = (exp_q.size() > 0) && rnd(p_ev);
    e_data_out = (exp_q.size() > 0) ? exp_q[0] : '0;
    mr[0] = toggle_m0 ? ~mr[0] : rnd(p_mr);
    mr[1] = rnd(p_mr);
  endtask

  // one clock: check at negedge, advance model after posedge
  task automatic tick();
    int o;
    bit rst, load, drain, ov, omr, in_fire, out_fire;
    @(negedge clk);
    rst   = reset;
    o     = m_owner;
    load  = (o >= 0) && !m_drain;
    drain = (o >= 0) && m_drain;
    ov    = (o == 1) ? sv[1] : sv[0];
    omr   = (o == 1) ? mr[1] : mr[0];
    chk("grant", 32'(grant), (o < 0) ? 32'd0 : ((o == 0) ? 32'd1 : 32'd2));
    chk("busy", b(busy), b(o >= 0));
    chk("s0_ready", b(s0_ready), b(load && o == 0 && e_s_ready));
    chk("s1_ready", b(s1_ready), b(load && o == 1 && e_s_ready));
    chk("m0_valid", b(m0_valid), b(drain && o == 0 && e_m_valid));
    chk("m1_valid", b(m1_valid), b(drain && o == 1 && e_m_valid));
    chk("e_s_valid", b(e_s_valid), b(load && ov));
    chk("e_m_ready", b(e_m_ready), b(drain && omr));
    if (load && ov)
      chk("e_data_in", 32'(e_data_in), 32'((o == 1) ? src1_q[0] : src0_q[0]));
    if (drain && e_m_valid)
      chk((o == 1) ? "m1_data" : "m0_data", 32'((o == 1) ? m1_data : m0_data), 32'(exp_q[0]));
    if (grant != 2'b00) begin
      if (prev_grant == 2'b00) begin
        grant_log.push_back(grant);
        gap_log.push_back(idle_run);
      end
      idle_run = 0;
    end else begin
      idle_run++;
    end
    prev_grant = grant;
    in_fire  = load && ov && e_s_ready;
    out_fire = drain && e_m_valid && omr;

    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
      drive_inputs(1'b0, 1'b0, 1'b0);
    end else begin
      if (o < 0) begin
        if (sv[0] && sv[1]) m_owner = m_ptr;
        else if (sv[0]) m_owner = 0;
        else if (sv[1]) m_owner = 1;
      end
      if (in_fire) begin
        if (o == 1) void'(src1_q.pop_front()); else void'(src0_q.pop_front());
        m_in++;
        if (m_in == N) begin
          m_in = 0;
          m_drain = 1'b1;
          for (int k = 0; k < M; k++) exp_q.push_back(WIDTH'($urandom));
        end
      end
      if (out_fire) begin
        void'(exp_q.pop_front());
        m_out++;
        if (m_out == M) begin
          m_out = 0;
          m_drain = 1'b0;
          m_owner = -1;
          m_ptr = 1 - o;
        end
      end
      drive_inputs(in_fire && o == 0, in_fire && o == 1, out_fire);
    end
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int c;
    c = 0;
    while (!(src0_q.size() == 0 && src1_q.size() == 0 && exp_q.size() == 0 && m_owner < 0)
           && c < budget) begin
      tick();
      c++;
    end
    chk({tag, "_finished"}, b(c < budget), 32'd1);
    tick();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] log_at(input int i);
    return (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hdead;
  endfunction

  function automatic logic [31:0] gap_at(input int i);
    return (i < gap_log.size()) ? 32'(gap_log[i]) : 32'hdead;
  endfunction

  initial begin
    int c;
    reset = 1'b1;
    p_sv = 100; p_er = 100; p_ev = 100; p_mr = 100;
    toggle_m0 = 1'b0;
    mr[0] = 1'b1; mr[1] = 1'b1; e_s_ready = 1'b1;
    prev_grant = 2'b00;
    clear_logs();
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", b(busy), 32'd0);

    // Only s0 active with beats 1..8
    clear_logs();
    push_txn(0, 1'b1);
    run_until_idle("solo_s0", 200);
    chk("solo_count", 32'(grant_log.size()), 32'd1);
    chk("solo_grant", log_at(0), 32'd1);
    chk("solo_busy_end", b(busy), 32'd0);

    // Simultaneous request after reset: s0 first, one idle cycle, then s1
    pulse_reset();
    clear_logs();
    push_txn(0, 1'b0);
    push_txn(1, 1'b0);
    run_until_idle("tie", 300);
    chk("tie_count", 32'(grant_log.size()), 32'd2);
    chk("tie_first", log_at(0), 32'd1);
    chk("tie_second", log_at(1), 32'd2);
    chk("tie_gap", gap_at(1), 32'd1);

    // Both held valid for 4 transactions: 01 10 01 10
    pulse_reset();
    clear_logs();
    push_txn(0, 1'b0); push_txn(0, 1'b0);
    push_txn(1, 1'b0); push_txn(1, 1'b0);
    run_until_idle("alt", 600);
    chk("alt_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("alt_grant", log_at(i), (i % 2 == 0) ? 32'd1 : 32'd2);
    for (int i = 1; i < 4; i++) chk("alt_gap", gap_at(i), 32'd1);

    // m0_ready toggling during DRAIN with a result stream held by the engine
    clear_logs();
    toggle_m0 = 1'b1;
    push_txn(0, 1'b0);
    run_until_idle("toggle", 300);
    toggle_m0 = 1'b0;
    mr[0] = 1'b1;
    chk("toggle_grant", log_at(0), 32'd1);

    // Reset after the 5th input beat abandons the transaction
    clear_logs();
    push_txn(0, 1'b1);
    c = 0;
    while (!(m_owner == 0 && !m_drain && m_in == 5) && c < 100) begin
      tick();
      c++;
    end
    chk("mid_reached", b(c < 100), 32'd1);
    reset = 1'b1;
    tick();
    chk("mid_grant", 32'(grant), 32'd0);
    chk("mid_busy", b(busy), 32'd0);
    chk("mid_s0_ready", b(s0_ready), 32'd0);
    chk("mid_s1_ready", b(s1_ready), 32'd0);
    chk("mid_e_s_valid", b(e_s_valid), 32'd0);
    chk("mid_e_m_ready", b(e_m_ready), 32'd0);
    reset = 1'b0;
    clear_logs();
    push_txn(1, 1'b0);
    run_until_idle("after_reset", 300);
    chk("after_reset_count", 32'(grant_log.size()), 32'd1);
    chk("after_reset_grant", log_at(0), 32'd2);

    // s1 raises valid while s0 is loading: waits for s0's DRAIN
    clear_logs();
    push_txn(0, 1'b0);
    c = 0;
    while (!(m_owner == 0 && !m_drain && m_in >= 2) && c < 100) begin
      tick();
      c++;
    end
    chk("late_reached", b(c < 100), 32'd1);
    push_txn(1, 1'b0);
    run_until_idle("late", 300);
    chk("late_count", 32'(grant_log.size()), 32'd2);
    chk("late_first", log_at(0), 32'd1);
    chk("late_second", log_at(1), 32'd2);

    // Randomized traffic with stalls on every channel
    p_sv = 70; p_er = 60; p_ev = 60; p_mr = 60;
    for (int t = 0; t < 6; t++) begin
      push_txn(int'($urandom_range(1, 0)), 1'b0);
      if (rnd(50)) push_txn(int'($urandom_range(1, 0)), 1'b0);
      for (int k = 0; k < int'($urandom_range(12, 0)); k++) tick();
    end
    run_until_idle("random", 4000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
